// File: rtl/msk_hpc2_rnd_supply_pkg.sv
// msk_rnd_pkg: shared types and constants for the HPC2 randomness supply
package msk_rnd_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;
    localparam int LFSR_W = 64;
    localparam int STEP_W = 32;
    // feedback taps for x^64+x^63+x^61+x^60+1: state bits 63, 62, 60, 59
    localparam logic [LFSR_W-1:0] TAPS = 64'hD800_0000_0000_0000;
    function automatic int hpc2rnd(input int d);
        return d * (d - 1) / 2;
    endfunction
endpackage

// File: rtl/msk_hpc2_rnd_supply_if.sv
// msk_hpc2_rnd_supply_if: seed handshake and randomness output bundle
interface msk_hpc2_rnd_supply_if #(parameter int RW = 1);
    logic [31:0]   seed;
    logic          seed_valid;
    logic          seed_ready;
    logic          rnd_en;
    logic [RW-1:0] rnd;
    logic          rnd_valid;
    modport master (output seed, seed_valid, rnd_en, input seed_ready, rnd, rnd_valid);
    modport slave  (input seed, seed_valid, rnd_en, output seed_ready, rnd, rnd_valid);
endinterface

// File: rtl/msk_hpc2_rnd_supply_lfsr.sv
// msk_lfsr64_step32: 32 unrolled Fibonacci LFSR steps, emitting the shifted-out bits LSB first
module msk_lfsr64_step32
    import msk_rnd_pkg::*;
(
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt,
    output logic [STEP_W-1:0] emit
);
    always_comb begin
        nxt = cur;
        emit = '0;
        for (int i = 0; i < STEP_W; i++) begin
            emit[i] = nxt[LFSR_W-1];
            nxt = {nxt[LFSR_W-2:0], ^(nxt & TAPS)};
        end
    end
endmodule

// File: rtl/msk_hpc2_rnd_supply.sv
// msk_hpc2_rnd_supply: seeded LFSR bank with warm-up supplying fresh randomness to HPC2 gadgets
module msk_hpc2_rnd_supply
    import msk_rnd_pkg::*;
#(
    parameter int d        = 2,
    parameter int NGADGETS = 1,
    parameter int WARMUP   = 16
) (
    input logic                  clk,
    input logic                  rst,
    msk_hpc2_rnd_supply_if.slave bus
);
    localparam int RW  = NGADGETS * hpc2rnd(d);
    localparam int NCH = (RW + 31) / 32;
    localparam int NW  = 2 * NCH;
    localparam int WCW = NW > 2 ? $clog2(NW) : 1;
    localparam int CW  = $clog2(WARMUP + 1);

    state_t                  state;
    logic [WCW-1:0]          wc;
    logic [CW-1:0]           warm_cnt;
    logic [LFSR_W-1:0]       chan [NCH];
    logic [LFSR_W-1:0]       nxt [NCH];
    logic [LFSR_W-1:0]       loaded [NCH];
    logic [STEP_W*NCH-1:0]   emit;
    logic [WCW-1:0]          idx;
    logic                    accept;
    logic                    last;
    logic                    unused_emit;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        msk_lfsr64_step32 u_step (.cur(chan[c]), .nxt(nxt[c]), .emit(emit[STEP_W*c +: STEP_W]));
    end

    assign accept      = bus.seed_valid & bus.seed_ready;
    assign idx         = state == LOAD ? wc : '0;
    assign last        = state == LOAD && int'(wc) == NW - 1;
    assign unused_emit = ^emit;

    // channel image after this word lands, with the all-zero guard on the final word
    always_comb begin
        logic [LFSR_W-1:0] w;
        w = '0;
        for (int c = 0; c < NCH; c++) begin
            w = int'(idx >> 1) == c ? (idx[0] ? {bus.seed, chan[c][31:0]} : {chan[c][63:32], bus.seed}) : chan[c];
            loaded[c] = last && w == '0 ? 64'h1 : w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wc             <= '0;
            warm_cnt       <= '0;
            chan           <= '{default: '0};
            bus.seed_ready <= 1'b1;
            bus.rnd        <= '0;
            bus.rnd_valid  <= 1'b0;
        end else if (state != WARM && accept) begin
            chan           <= loaded;
            wc             <= idx + 1'b1;
            warm_cnt       <= '0;
            state          <= last ? WARM : LOAD;
            bus.seed_ready <= !last;
            bus.rnd        <= '0;
            bus.rnd_valid  <= 1'b0;
        end else if (state == WARM) begin
            chan     <= nxt;
            warm_cnt <= warm_cnt + 1'b1;
            if (int'(warm_cnt) == WARMUP - 1) begin
                state          <= RUN;
                bus.seed_ready <= 1'b1;
                bus.rnd        <= emit[RW-1:0];
                bus.rnd_valid  <= 1'b1;
            end
        end else if (state == RUN && bus.rnd_en) begin
            chan    <= nxt;
            bus.rnd <= emit[RW-1:0];
        end
    end
endmodule

// File: tb/tb_msk_hpc2_rnd_supply.sv
// tb_msk_hpc2_rnd_supply: randomized self-checking bench against a bit-serial LFSR reference
module tb_msk_hpc2_rnd_supply;
    localparam int D   = 3;
    localparam int NG  = 1;
    localparam int WU  = 4;
    localparam int RW  = NG * D * (D - 1) / 2;
    localparam int NCH = (RW + 31) / 32;
    typedef logic [31:0] words_t [2*NCH];

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [63:0]   m [NCH];
    logic [RW-1:0] exp_rnd;

    always #5 clk = ~clk;

    msk_hpc2_rnd_supply_if #(.RW(RW)) bus ();
    msk_hpc2_rnd_supply #(.d(D), .NGADGETS(NG), .WARMUP(WU)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one polynomial step per emitted bit: output the top bit, shift in the tap parity
    task automatic model_advance();
        logic [32*NCH-1:0] cat;
        cat = '0;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 32; i++) begin
                cat[32*c+i] = m[c][63];
                m[c] = {m[c][62:0], m[c][63] ^ m[c][62] ^ m[c][60] ^ m[c][59]};
            end
        exp_rnd = cat[RW-1:0];
    endtask

    task automatic model_load(input words_t ws);
        for (int k = 0; k < 2 * NCH; k++) m[k/2][32*(k%2) +: 32] = ws[k];
        for (int c = 0; c < NCH; c++) if (m[c] == 64'h0) m[c] = 64'h1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.seed = w;
        bus.seed_valid = 1'b1;
        tick();
        bus.seed_valid = 1'b0;
    endtask

    task automatic seed_full(input words_t ws);
        for (int k = 0; k < 2 * NCH; k++) send_word(ws[k]);
        model_load(ws);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.seed = '0;
        bus.seed_valid = 1'b0;
        bus.rnd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_warm(input string tag);
        int n = 0;
        tests++;
        if (bus.seed_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_ready_in_warm got %b want 0", tag, bus.seed_ready);
        end
        while (bus.rnd_valid !== 1'b1 && n < WU + 8) begin
            tests++;
            if (bus.rnd !== '0) begin
                fails++;
                $display("FAIL %s_rnd_masked got %h want 0", tag, bus.rnd);
            end
            tick();
            n++;
        end
        tests++;
        if (n != WU) begin
            fails++;
            $display("FAIL %s_warm_latency got %0d want %0d", tag, n, WU);
        end
        repeat (WU) model_advance();
        tests++;
        if (bus.rnd !== exp_rnd) begin
            fails++;
            $display("FAIL %s_first_rnd got %h want %h", tag, bus.rnd, exp_rnd);
        end
    endtask

    task automatic run_cycles(input string tag, input int n, input bit rand_en);
        for (int i = 0; i < n; i++) begin
            bus.rnd_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (bus.rnd_en) model_advance();
            tests++;
            if (bus.rnd_valid !== 1'b1 || bus.rnd !== exp_rnd) begin
                fails++;
                $display("FAIL %s_run[%0d] got valid=%b rnd=%h want valid=1 rnd=%h", tag, i, bus.rnd_valid, bus.rnd, exp_rnd);
            end
        end
        bus.rnd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({bus.seed_ready, bus.rnd_valid, bus.rnd} !== {1'b1, 1'b0, {RW{1'b0}}}) begin
                fails++;
                $display("FAIL reset_idle[%0d] got ready=%b valid=%b rnd=%h want 1 0 0", i, bus.seed_ready, bus.rnd_valid, bus.rnd);
            end
            tick();
        end
    endtask

    task automatic test_seed_warmup();
        words_t w;
        w[0] = 32'h12345678;
        w[1] = 32'h9ABCDEF0;
        seed_full(w);
        wait_warm("fixed");
        run_cycles("fixed", 1000, 1'b0);
    endtask

    task automatic test_zero_seed();
        words_t w;
        int ones = 0;
        do_reset();
        w[0] = '0;
        w[1] = '0;
        seed_full(w);
        wait_warm("zero");
        for (int i = 0; i < 64; i++) begin
            bus.rnd_en = 1'b1;
            tick();
            model_advance();
            tests++;
            if (bus.rnd !== exp_rnd) begin
                fails++;
                $display("FAIL zero_run[%0d] got %h want %h", i, bus.rnd, exp_rnd);
            end
            ones += $countones(bus.rnd);
        end
        bus.rnd_en = 1'b0;
        tests++;
        if (ones == 0) begin
            fails++;
            $display("FAIL zero_stuck got %0d ones want nonzero", ones);
        end
    endtask

    task automatic test_enable_toggle();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.rnd_en = pat[i];
            tick();
            if (pat[i]) model_advance();
            tests++;
            if (bus.rnd_valid !== 1'b1 || bus.rnd !== exp_rnd) begin
                fails++;
                $display("FAIL toggle[%0d] got valid=%b rnd=%h want valid=1 rnd=%h", i, bus.rnd_valid, bus.rnd, exp_rnd);
            end
        end
        run_cycles("rand_en", 200, 1'b1);
    endtask

    task automatic test_reseed();
        words_t w;
        w[0] = $urandom;
        w[1] = $urandom;
        bus.seed = w[0];
        bus.seed_valid = 1'b1;
        bus.rnd_en = 1'b1;
        tick();
        bus.seed_valid = 1'b0;
        bus.rnd_en = 1'b0;
        tests++;
        if (bus.rnd_valid !== 1'b0 || bus.rnd !== '0 || bus.seed_ready !== 1'b1) begin
            fails++;
            $display("FAIL reseed_drop got valid=%b rnd=%h ready=%b want 0 0 1", bus.rnd_valid, bus.rnd, bus.seed_ready);
        end
        send_word(w[1]);
        model_load(w);
        wait_warm("reseed");
        run_cycles("reseed", 50, 1'b1);
    endtask

    task automatic test_partial_reset();
        words_t w;
        do_reset();
        send_word($urandom);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.rnd_valid !== 1'b0 || bus.seed_ready !== 1'b1) begin
            fails++;
            $display("FAIL partial_reset got valid=%b ready=%b want 0 1", bus.rnd_valid, bus.seed_ready);
        end
        w[0] = $urandom;
        w[1] = $urandom;
        send_word(w[0]);
        for (int i = 0; i < WU + 4; i++) begin
            tests++;
            if (bus.rnd_valid !== 1'b0 || bus.seed_ready !== 1'b1) begin
                fails++;
                $display("FAIL partial_wait[%0d] got valid=%b ready=%b want 0 1", i, bus.rnd_valid, bus.seed_ready);
            end
            tick();
        end
        send_word(w[1]);
        model_load(w);
        wait_warm("partial");
        run_cycles("partial", 50, 1'b1);
    endtask

    initial begin
        test_reset();
        test_seed_warmup();
        test_zero_seed();
        test_enable_toggle();
        test_reseed();
        test_partial_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
